// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write-port arbiter with credit tracking for sync_fifo
//
// Shares the single write port of sync_fifo among NREQ producers. A credit
// counter (level) covers entries already in the FIFO plus the one in flight
// in the write register, so a write is never issued to a full FIFO. A
// flush/drain handshake stops granting until the consumer empties the FIFO.
//
// Optional feature: define FIFO_WR_ARB_STATS_EN to add per-requester
// saturating grant counters on port gnt_cnt.
//
// Ports:
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   req            per-requester write request, held until granted
//   req_data       per-requester write data, packed [NREQ-1:0][WIDTH-1:0]
//   gnt            one-hot combinational grant; data is taken at this edge
//   fifo_wr_en     registered FIFO write strobe
//   fifo_wr_data   registered FIFO write data
//   fifo_rd_valid  FIFO pop accepted this cycle
//   fifo_full      FIFO full flag, used only by the overflow check
//   flush          drain request, sampled in RUN
//   flush_done     one-cycle pulse when the drain completes
//   level          credit count: entries in the FIFO plus in flight
//   almost_full    level >= SIZE-ALERT_DEPTH
//   gnt_cnt        per-requester grant counters (FIFO_WR_ARB_STATS_EN only)

module fifo_wr_arbiter #(
   parameter int NREQ        = 4,
   parameter int WIDTH       = 32,
   parameter int SIZE        = 16,
   parameter int ALERT_DEPTH = 3,
   localparam int LW         = $clog2(SIZE + 1),
   localparam int PW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [NREQ-1:0]             req,
   input  logic [NREQ-1:0][WIDTH-1:0]  req_data,
   output logic [NREQ-1:0]             gnt,
   output logic                        fifo_wr_en,
   output logic [WIDTH-1:0]            fifo_wr_data,
   input  logic                        fifo_rd_valid,
   input  logic                        fifo_full,
   input  logic                        flush,
   output logic                        flush_done,
   output logic [LW-1:0]               level,
   output logic                        almost_full
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [NREQ-1:0][15:0]       gnt_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   win;
   logic [PW-1:0]   cand;
   logic            found;
   logic            can_issue;
   logic            any_gnt;

   assign can_issue   = (level < LW'(SIZE));
   assign almost_full = (level >= LW'(SIZE - ALERT_DEPTH));

   // Search starts at rr_ptr and wraps, so the last winner has lowest priority.
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         cand = PW'((int'(rr_ptr) + k) % NREQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // reset_n gates the grant so it drops immediately, not at the next edge.
   always_comb begin
      gnt = '0;
      if (reset_n && state == RUN && can_issue && found) begin
         gnt[win] = 1'b1;
      end
   end

   assign any_gnt = |gnt;

   always_comb begin
      state_nxt  = state;
      flush_done = 1'b0;
      case (state)
         RUN:     if (flush) state_nxt = DRAIN;
         DRAIN:   if (level == '0) state_nxt = DONE;
         DONE: begin
            flush_done = 1'b1;
            state_nxt  = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= RUN;
         rr_ptr       <= '0;
         fifo_wr_en   <= 1'b0;
         fifo_wr_data <= '0;
         level        <= '0;
      end else begin
         state      <= state_nxt;
         fifo_wr_en <= any_gnt;
         if (any_gnt) begin
            fifo_wr_data <= req_data[win];
            rr_ptr       <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
         end
         // A pop at level==0 is illegal; the counter holds instead of wrapping.
         if (any_gnt && !fifo_rd_valid) begin
            level <= level + 1'b1;
         end else if (!any_gnt && fifo_rd_valid && level != '0) begin
            level <= level - 1'b1;
         end
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         gnt_cnt <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (gnt[i] && gnt_cnt[i] != 16'hFFFF) begin
               gnt_cnt[i] <= gnt_cnt[i] + 16'd1;
            end
         end
      end
   end
`endif

   a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
      !(fifo_rd_valid && level == '0));

   a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
      !(fifo_wr_en && fifo_full && !fifo_rd_valid));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter

module tb_fifo_wr_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 32;
   localparam int SIZE  = 16;
   localparam int LW    = $clog2(SIZE + 1);

   logic                        clock;
   logic                        reset_n;
   logic [NREQ-1:0]             req;
   logic [NREQ-1:0][WIDTH-1:0]  req_data;
   logic [NREQ-1:0]             gnt;
   logic                        fifo_wr_en;
   logic [WIDTH-1:0]            fifo_wr_data;
   logic                        fifo_rd_valid;
   logic                        fifo_full;
   logic                        flush;
   logic                        flush_done;
   logic [LW-1:0]               level;
   logic                        almost_full;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [NREQ-1:0][15:0]       gnt_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   fifo_wr_arbiter #(
      .NREQ(NREQ), .WIDTH(WIDTH), .SIZE(SIZE), .ALERT_DEPTH(3)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .req(req),
      .req_data(req_data),
      .gnt(gnt),
      .fifo_wr_en(fifo_wr_en),
      .fifo_wr_data(fifo_wr_data),
      .fifo_rd_valid(fifo_rd_valid),
      .fifo_full(fifo_full),
      .flush(flush),
      .flush_done(flush_done),
      .level(level),
      .almost_full(almost_full)
`ifdef FIFO_WR_ARB_STATS_EN
      ,
      .gnt_cnt(gnt_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] dv(input int i);
      return 32'hC0DE_0000 + 32'(i);
   endfunction

   logic [3:0] exp1 [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                            4'b0001, 4'b0010, 4'b0100, 4'b1000};
   int         win1 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   logic [3:0] exp2 [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
   logic [3:0] exp3 [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};

   initial begin
      reset_n       = 1'b0;
      flush         = 1'b0;
      fifo_rd_valid = 1'b0;
      fifo_full     = 1'b0;
      for (int i = 0; i < NREQ; i++) req_data[i] = dv(i);
      req = 4'b1111;

      // Reset: grant suppressed even with requests pending.
      @(negedge clock);
      check("rst_gnt", 64'(gnt), 64'h0);
      check("rst_wr_en", 64'(fifo_wr_en), 64'h0);
      check("rst_wr_data", 64'(fifo_wr_data), 64'h0);
      check("rst_level", 64'(level), 64'h0);
      check("rst_almost_full", 64'(almost_full), 64'h0);
      check("rst_flush_done", 64'(flush_done), 64'h0);

      // 1: all requesting, round-robin 0..3 twice.
      tick();
      reset_n = 1'b1;
      req     = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         check($sformatf("t1_gnt%0d", c), 64'(gnt), 64'(exp1[c]));
         if (c > 0) check($sformatf("t1_data%0d", c), 64'(fifo_wr_data), 64'(dv(win1[c-1])));
         tick();
      end
      req = 4'b0000;
      @(negedge clock);
      check("t1_gnt_idle", 64'(gnt), 64'h0);
      check("t1_wr_en", 64'(fifo_wr_en), 64'h1);
      check("t1_last_data", 64'(fifo_wr_data), 64'(dv(3)));
      check("t1_level", 64'(level), 64'd8);

      // 2: sparse requests alternate 0,2.
      tick();
      req = 4'b0101;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         check($sformatf("t2_gnt%0d", c), 64'(gnt), 64'(exp2[c]));
         tick();
      end
      req = 4'b0000;
      @(negedge clock);
      check("t2_level", 64'(level), 64'd12);
      check("t2_almost_full_12", 64'(almost_full), 64'h0);
      check("t2_data", 64'(fifo_wr_data), 64'(dv(2)));

      // 5: grant and pop together at level 13.
      tick();
      req = 4'b0001;
      @(negedge clock);
      check("t5_gnt0", 64'(gnt), 64'b0001);
      tick();
      req = 4'b0010;
      fifo_rd_valid = 1'b1;
      @(negedge clock);
      check("t5_level13", 64'(level), 64'd13);
      check("t5_almost_full_13", 64'(almost_full), 64'h1);
      check("t5_gnt1", 64'(gnt), 64'b0010);
      tick();
      req = 4'b0000;
      @(negedge clock);
      check("t5_level_same", 64'(level), 64'd13);
      tick();
      fifo_rd_valid = 1'b0;
      @(negedge clock);
      check("t5_level12", 64'(level), 64'd12);
      check("t5_almost_full_12", 64'(almost_full), 64'h0);

      // 3: fill to 16, stall, single pop frees one credit a cycle later.
      tick();
      req = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         check($sformatf("t3_gnt%0d", c), 64'(gnt), 64'(exp3[c]));
         tick();
      end
      @(negedge clock);
      check("t3_level16", 64'(level), 64'd16);
      check("t3_gnt_full", 64'(gnt), 64'h0);
      check("t3_wr_en_last", 64'(fifo_wr_en), 64'h1);
      tick();
      @(negedge clock);
      check("t3_gnt_full2", 64'(gnt), 64'h0);
      check("t3_wr_en_off", 64'(fifo_wr_en), 64'h0);
      tick();
      fifo_rd_valid = 1'b1;
      @(negedge clock);
      check("t3_gnt_pop_cycle", 64'(gnt), 64'h0);
      tick();
      fifo_rd_valid = 1'b0;
      @(negedge clock);
      check("t3_level15", 64'(level), 64'd15);
      check("t3_gnt_regrant", 64'(gnt), 64'b0100);
      tick();
      req = 4'b0000;
      @(negedge clock);
      check("t3_level_refill", 64'(level), 64'd16);

      // 4: drain to level 4, flush with requests active.
      tick();
      fifo_rd_valid = 1'b1;
      repeat (12) tick();
      fifo_rd_valid = 1'b0;
      req   = 4'b1111;
      flush = 1'b1;
      @(negedge clock);
      check("t4_level4", 64'(level), 64'd4);
      check("t4_gnt_flush_cycle", 64'(gnt), 64'b1000);
      tick();
      flush = 1'b0;
      @(negedge clock);
      check("t4_level5", 64'(level), 64'd5);
      check("t4_gnt_drain", 64'(gnt), 64'h0);
      tick();
      fifo_rd_valid = 1'b1;
      for (int p = 0; p < 5; p++) begin
         @(negedge clock);
         check($sformatf("t4_drain_gnt%0d", p), 64'(gnt), 64'h0);
         check($sformatf("t4_drain_lvl%0d", p), 64'(level), 64'(5 - p));
         tick();
      end
      fifo_rd_valid = 1'b0;
      @(negedge clock);
      check("t4_level0", 64'(level), 64'd0);
      check("t4_done_early", 64'(flush_done), 64'h0);
      tick();
      @(negedge clock);
      check("t4_done", 64'(flush_done), 64'h1);
      check("t4_gnt_done", 64'(gnt), 64'h0);
      tick();
      @(negedge clock);
      check("t4_done_clear", 64'(flush_done), 64'h0);
      check("t4_gnt_run", 64'(gnt), 64'b0001);
      tick();
      @(negedge clock);
      check("t4_gnt_run2", 64'(gnt), 64'b0010);
      check("t4_level1", 64'(level), 64'd1);

      // 6: asynchronous reset mid-burst, checked before any clock edge.
      tick();
      reset_n = 1'b0;
      #1;
      check("t6_gnt", 64'(gnt), 64'h0);
      check("t6_wr_en", 64'(fifo_wr_en), 64'h0);
      check("t6_level", 64'(level), 64'h0);
`ifdef FIFO_WR_ARB_STATS_EN
      check("t6_gnt_cnt", 64'(gnt_cnt), 64'h0);
`endif
      tick();
      reset_n = 1'b1;
      @(negedge clock);
      check("t6_rr_ptr_cleared", 64'(gnt), 64'b0001);
      tick();
      req = 4'b0000;
      @(negedge clock);
      check("t6_level_after", 64'(level), 64'd1);
      check("t6_data_after", 64'(fifo_wr_data), 64'(dv(0)));
`ifdef FIFO_WR_ARB_STATS_EN
      check("t6_gnt_cnt0", 64'(gnt_cnt[0]), 64'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
